// File: rtl/motor_ctrl_pkg.sv
// Shared types for the line-following drive controller:
// FSM state encodings, sensor decode classes and wheel direction values.
package motor_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FORWARD    = 3'd1,
        ST_TURN_LEFT  = 3'd2,
        ST_TURN_RIGHT = 3'd3,
        ST_SEARCH     = 3'd4,
        ST_STOP       = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        DEC_FWD,
        DEC_LEFT,
        DEC_RIGHT,
        DEC_HOLD,
        DEC_LOST
    } dec_t;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    localparam logic [2:0] SNS_CENTRE  = 3'b010;
    localparam logic [2:0] SNS_ALL     = 3'b111;
    localparam logic [2:0] SNS_LEFT_C  = 3'b110;
    localparam logic [2:0] SNS_LEFT    = 3'b100;
    localparam logic [2:0] SNS_RIGHT_C = 3'b011;
    localparam logic [2:0] SNS_RIGHT   = 3'b001;
    localparam logic [2:0] SNS_SPLIT   = 3'b101;

    function automatic dec_t decode(input logic [2:0] s);
        dec_t d;
        case (s)
            SNS_CENTRE, SNS_ALL:    d = DEC_FWD;
            SNS_LEFT_C, SNS_LEFT:   d = DEC_LEFT;
            SNS_RIGHT_C, SNS_RIGHT: d = DEC_RIGHT;
            SNS_SPLIT:              d = DEC_HOLD;
            default:                d = DEC_LOST;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/duty_ramp.sv
// Per-wheel slew limiter: moves duty toward a target by at most STEP per
// tick and only reverses direction once duty has reached zero.
// Ports: clk, reset (async, high), tick, tgt_duty/tgt_dir in; duty/dir out.
module duty_ramp #(
    parameter int STEP = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [9:0] tgt_duty,
    input  logic       tgt_dir,
    output logic [9:0] duty,
    output logic       dir
);
    import motor_ctrl_pkg::*;

    localparam logic [10:0] STEP11 = 11'(STEP);

    logic [10:0] cur;
    logic [10:0] eff;
    logic [10:0] up;
    logic [10:0] dn;
    logic [9:0]  nxt;

    // A pending reversal first drives the wheel down to zero.
    always_comb begin
        cur = {1'b0, duty};
        eff = (tgt_dir != dir) ? 11'd0 : {1'b0, tgt_duty};
        up  = cur + STEP11;
        dn  = cur - STEP11;
        nxt = duty;
        if (cur < eff) begin
            nxt = (up > eff) ? eff[9:0] : up[9:0];
        end else if (cur > eff) begin
            nxt = (cur < STEP11 || dn < eff) ? eff[9:0] : dn[9:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty <= '0;
            dir  <= DIR_FWD;
        end else if (tick) begin
            if (tgt_dir != dir && duty == 10'd0) begin
                dir <= tgt_dir;
            end else begin
                duty <= nxt;
            end
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Line-following drive controller: sensor-decoded FSM with line-loss
// search, feeding two slew-limited wheel duty/direction channels.
// Ports: clk, reset (async, high), enable, sensor[2:0] in;
//        left/right_duty[9:0], left/right_dir, state[2:0] out.
module motor_ramp_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int STEP         = 16,
    parameter int V_FWD        = 1023,
    parameter int V_SLOW       = 800,
    parameter int V_SPIN       = 700,
    parameter int LOST_TICKS   = 200,
    parameter int SEARCH_TICKS = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] sensor,
    output logic [9:0] left_duty,
    output logic [9:0] right_duty,
    output logic       left_dir,
    output logic       right_dir,
    output logic [2:0] state
);
    import motor_ctrl_pkg::*;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LW = $clog2(LOST_TICKS + 1);
    localparam int SW = $clog2(SEARCH_TICKS + 1);

    localparam logic [9:0] D_FWD  = 10'(V_FWD);
    localparam logic [9:0] D_SLOW = 10'(V_SLOW);
    localparam logic [9:0] D_SPIN = 10'(V_SPIN);

    logic [TW-1:0] tick_cnt;
    logic          tick;
    state_t        st;
    logic [LW-1:0] lost_cnt;
    logic [SW-1:0] search_cnt;
    logic          last_turn;
    dec_t          dec;

    logic [9:0] l_tgt;
    logic [9:0] r_tgt;
    logic       l_tdir;
    logic       r_tdir;

    assign tick  = (tick_cnt == TW'(TICK_DIV - 1));
    assign dec   = decode(sensor);
    assign state = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= ST_IDLE;
            lost_cnt   <= '0;
            search_cnt <= '0;
            last_turn  <= 1'b0;
        end else if (tick) begin
            if (!enable) begin
                st         <= ST_IDLE;
                lost_cnt   <= '0;
                search_cnt <= '0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        lost_cnt <= '0;
                        case (dec)
                            DEC_FWD: st <= ST_FORWARD;
                            DEC_LEFT: begin
                                st        <= ST_TURN_LEFT;
                                last_turn <= 1'b0;
                            end
                            DEC_RIGHT: begin
                                st        <= ST_TURN_RIGHT;
                                last_turn <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    ST_STOP: ;
                    default: begin
                        case (dec)
                            DEC_FWD: begin
                                st       <= ST_FORWARD;
                                lost_cnt <= '0;
                            end
                            DEC_LEFT: begin
                                st        <= ST_TURN_LEFT;
                                last_turn <= 1'b0;
                                lost_cnt  <= '0;
                            end
                            DEC_RIGHT: begin
                                st        <= ST_TURN_RIGHT;
                                last_turn <= 1'b1;
                                lost_cnt  <= '0;
                            end
                            DEC_HOLD: begin
                                lost_cnt <= '0;
                                if (st == ST_SEARCH) st <= ST_FORWARD;
                            end
                            default: begin
                                if (st == ST_SEARCH) begin
                                    if (search_cnt == SW'(SEARCH_TICKS - 1))
                                        st <= ST_STOP;
                                    else
                                        search_cnt <= search_cnt + 1'b1;
                                end else if (lost_cnt == LW'(LOST_TICKS - 1)) begin
                                    st         <= ST_SEARCH;
                                    lost_cnt   <= '0;
                                    search_cnt <= '0;
                                end else begin
                                    lost_cnt <= lost_cnt + 1'b1;
                                end
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    // Targets follow the registered state, so the ramp lags a transition
    // by one tick.
    always_comb begin
        l_tgt  = '0;
        r_tgt  = '0;
        l_tdir = left_dir;
        r_tdir = right_dir;
        case (st)
            ST_FORWARD: begin
                l_tgt  = D_FWD;
                r_tgt  = D_FWD;
                l_tdir = DIR_FWD;
                r_tdir = DIR_FWD;
            end
            ST_TURN_LEFT: begin
                l_tgt  = D_SLOW;
                r_tgt  = D_FWD;
                l_tdir = DIR_FWD;
                r_tdir = DIR_FWD;
            end
            ST_TURN_RIGHT: begin
                l_tgt  = D_FWD;
                r_tgt  = D_SLOW;
                l_tdir = DIR_FWD;
                r_tdir = DIR_FWD;
            end
            ST_SEARCH: begin
                l_tgt  = D_SPIN;
                r_tgt  = D_SPIN;
                l_tdir = last_turn ? DIR_FWD : DIR_REV;
                r_tdir = last_turn ? DIR_REV : DIR_FWD;
            end
            default: ;
        endcase
    end

    duty_ramp #(.STEP(STEP)) u_left (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .tgt_duty (l_tgt),
        .tgt_dir  (l_tdir),
        .duty     (left_duty),
        .dir      (left_dir)
    );

    duty_ramp #(.STEP(STEP)) u_right (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .tgt_duty (r_tgt),
        .tgt_dir  (r_tdir),
        .duty     (right_duty),
        .dir      (right_dir)
    );

endmodule
